risc_sequencer: RTL
===================

// Module: risc_sequencer
// PURPOSE
//  Control sequencer for the VERI_RISC core: 8-phase instruction-cycle state machine.
//  Decodes the IR opcode and accumulator zero flag into datapath strobes.
//  Strobes: address mux select, memory read/write, IR/AC/PC load, PC increment, data-bus enable.
//  Sits between IR/accumulator and PC/memory/ALU; owns halt and instruction-retire counting.
// PARAMETERS
//  CNT_W      16   width of retired-instruction counter instr_cnt
//  MEM_STALL  1    1: honour mem_ready in fetch phases; 0: ignore mem_ready (fixed 8-clock cycle)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-low reset
//  opcode     in   3      IR[7:5]: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//  zero       in   1      accumulator == 0
//  mem_ready  in   1      memory read data valid this cycle
//  sel        out  1      address mux: 1=PC, 0=IR operand
//  rd         out  1      memory read enable
//  ld_ir      out  1      load instruction register
//  inc_pc     out  1      increment program counter
//  ld_pc      out  1      load PC from IR operand
//  data_e     out  1      drive AC onto data bus
//  ld_ac      out  1      load accumulator from ALU
//  wr         out  1      memory write strobe
//  halt       out  1      core halted
//  phase      out  3      current phase, for debug/trace
//  instr_cnt  out  CNT_W  instructions retired since reset, saturating
// BEHAVIOUR
//  Reset (rst low, async): phase=0, halted=0, instr_cnt=0.
//   Outputs during reset: sel=1, all other strobes 0, halt=0.
//  Phases, advancing +1 per clk unless stalled or halted; 7 wraps to 0.
//   ALUOP = ADD|AND|XOR|LDA.
//   0 INST_ADDR : sel
//   1 INST_FETCH: sel rd
//   2 INST_LOAD : sel rd ld_ir
//   3 IDLE      : sel rd ld_ir
//   4 OP_ADDR   : inc_pc; halt=(opcode==HLT)
//   5 OP_FETCH  : rd=ALUOP
//   6 ALU_OP    : rd=ALUOP; inc_pc=(SKZ&zero); ld_pc=JMP; data_e=STO
//   7 STORE     : rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO
//  Strobes are combinational from registered phase, opcode and zero. No registered output latency.
//  Stall (MEM_STALL=1): in phase 1 always, and in phase 5 only when ALUOP, hold phase while mem_ready=0.
//   Held phase keeps its strobes asserted. mem_ready is ignored in all other phases.
//  HLT: in phase 4 with opcode==HLT, set halted on the clock edge; phase freezes at 4.
//   While halted: halt=1 and every other strobe is 0. Only reset exits halt.
//  Retire: instr_cnt+1 on each 7->0 transition; saturates at all-ones.
//   A HLT instruction never retires.
//  Reset mid-instruction: immediate return to phase 0; any partial strobe is abandoned.
//  zero and opcode are sampled combinationally. Upstream holds them stable phases 4-7.
// CONFIGURATION
//  SINGLE_STEP_EN defined adds two ports:
//   step_mode  in  1  pause enable
//   step       in  1  one-clock resume pulse
//  With SINGLE_STEP_EN: when step_mode=1, sequencer holds phase 0 (sel=1 only).
//   It advances past phase 0 on a clock where step=1, then runs one full instruction.
//   step pulses outside phase 0 are ignored.
//   Clearing step_mode resumes free-running on the next clock.
//  Without SINGLE_STEP_EN: ports absent; phase 0 always advances.
// TESTING
//  1 Reset: assert rst=0 mid-phase 5 -> phase=0, sel=1, all strobes 0, instr_cnt=0.
//  2 HLT at addr 0, mem_ready=1: release reset -> halt=0 after 3 clocks, halt=1 on clock 4.
//    halt holds for 20 more clocks; instr_cnt=0.
//  3 JMP 2 at addr 0, HLT at 2 -> ld_pc=1 in phases 6-7, inc_pc=0 in phase 6, halt=1 on clock 12.
//    instr_cnt=1.
//  4 SKZ with zero=1 -> inc_pc=1 in phases 4 and 6. With zero=0 -> inc_pc=1 in phase 4 only.
//  5 STO -> data_e=1 phases 6-7, wr=1 phase 7 only, rd=0 phases 5-7, ld_ac=0.
//    LDA -> rd phases 5-7, ld_ac phase 7.
//  6 MEM_STALL=1, mem_ready=0 for 3 clocks in phase 1 -> phase stays 1 with sel=rd=1.
//    Instruction completes 3 clocks later than unstalled. Same in phase 5 for ADD.
//    STO ignores mem_ready in phase 5.

Source files
------------

// File: rtl/risc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : risc_sequencer_if                                            |
// | Description : Control bus between the VERI_RISC sequencer and the datapath |
// |               (IR/accumulator inputs, datapath strobes, trace outputs).    |
// |               Macro SINGLE_STEP_EN adds the i_step_mode / i_step pair.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface risc_sequencer_if #(
    parameter int CNT_W = 16
);
    // Datapath -> sequencer
    logic [2:0]       i_opcode;
    logic             i_zero;
    logic             i_mem_ready;
`ifdef SINGLE_STEP_EN
    logic             i_step_mode;
    logic             i_step;
`endif

    // Sequencer -> datapath
    logic             o_sel;
    logic             o_rd;
    logic             o_ld_ir;
    logic             o_inc_pc;
    logic             o_ld_pc;
    logic             o_data_e;
    logic             o_ld_ac;
    logic             o_wr;
    logic             o_halt;
    logic [2:0]       o_phase;
    logic [CNT_W-1:0] o_instr_cnt;

`ifdef SINGLE_STEP_EN
    modport master (
        input  i_opcode, i_zero, i_mem_ready, i_step_mode, i_step,
        output o_sel, o_rd, o_ld_ir, o_inc_pc, o_ld_pc, o_data_e,
               o_ld_ac, o_wr, o_halt, o_phase, o_instr_cnt
    );
    modport slave (
        output i_opcode, i_zero, i_mem_ready, i_step_mode, i_step,
        input  o_sel, o_rd, o_ld_ir, o_inc_pc, o_ld_pc, o_data_e,
               o_ld_ac, o_wr, o_halt, o_phase, o_instr_cnt
    );
`else
    modport master (
        input  i_opcode, i_zero, i_mem_ready,
        output o_sel, o_rd, o_ld_ir, o_inc_pc, o_ld_pc, o_data_e,
               o_ld_ac, o_wr, o_halt, o_phase, o_instr_cnt
    );
    modport slave (
        output i_opcode, i_zero, i_mem_ready,
        input  o_sel, o_rd, o_ld_ir, o_inc_pc, o_ld_pc, o_data_e,
               o_ld_ac, o_wr, o_halt, o_phase, o_instr_cnt
    );
`endif

endinterface : risc_sequencer_if
`default_nettype wire

// File: rtl/risc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : risc_sequencer                                               |
// | Description : 8-phase instruction-cycle controller for the VERI_RISC core; |
// |               decodes opcode/zero into datapath strobes, owns halt and the |
// |               saturating retired-instruction counter.                      |
// |               Macro SINGLE_STEP_EN enables single-step pausing in phase 0. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module risc_sequencer #(
    parameter int CNT_W     = 16,
    parameter bit MEM_STALL = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    risc_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] c_OP_HLT = 3'd0;
    localparam logic [2:0] c_OP_SKZ = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_AND = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_LDA = 3'd5;
    localparam logic [2:0] c_OP_STO = 3'd6;
    localparam logic [2:0] c_OP_JMP = 3'd7;

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic             r_halted;
    logic             w_halted_nxt;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] w_instr_cnt_nxt;

    logic w_is_hlt;
    logic w_is_skz;
    logic w_is_sto;
    logic w_is_jmp;
    logic w_aluop;
    logic w_mem_go;
    logic w_step_go;

    logic w_sel;
    logic w_rd;
    logic w_ld_ir;
    logic w_inc_pc;
    logic w_ld_pc;
    logic w_data_e;
    logic w_ld_ac;
    logic w_wr;
    logic w_halt;

    assign w_is_hlt = (bus.i_opcode == c_OP_HLT);
    assign w_is_skz = (bus.i_opcode == c_OP_SKZ);
    assign w_is_sto = (bus.i_opcode == c_OP_STO);
    assign w_is_jmp = (bus.i_opcode == c_OP_JMP);
    assign w_aluop  = (bus.i_opcode == c_OP_ADD) || (bus.i_opcode == c_OP_AND) ||
                      (bus.i_opcode == c_OP_XOR) || (bus.i_opcode == c_OP_LDA);

    // With stalling disabled the memory is assumed to answer within a fixed cycle.
    assign w_mem_go = !MEM_STALL || bus.i_mem_ready;

`ifdef SINGLE_STEP_EN
    assign w_step_go = !bus.i_step_mode || bus.i_step;
`else
    assign w_step_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= PH_INST_ADDR;
            r_halted    <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_halted    <= w_halted_nxt;
            r_instr_cnt <= w_instr_cnt_nxt;
        end
    end

    always_comb begin
        w_phase_nxt     = r_phase;
        w_halted_nxt    = r_halted;
        w_instr_cnt_nxt = r_instr_cnt;
        w_sel           = 1'b0;
        w_rd            = 1'b0;
        w_ld_ir         = 1'b0;
        w_inc_pc        = 1'b0;
        w_ld_pc         = 1'b0;
        w_data_e        = 1'b0;
        w_ld_ac         = 1'b0;
        w_wr            = 1'b0;
        w_halt          = 1'b0;

        if (r_halted) begin
            w_halt = 1'b1;
        end else begin
            case (r_phase)
                PH_INST_ADDR: begin
                    w_sel = 1'b1;
                    if (w_step_go) begin
                        w_phase_nxt = PH_INST_FETCH;
                    end
                end
                PH_INST_FETCH: begin
                    w_sel = 1'b1;
                    w_rd  = 1'b1;
                    if (w_mem_go) begin
                        w_phase_nxt = PH_INST_LOAD;
                    end
                end
                PH_INST_LOAD: begin
                    w_sel       = 1'b1;
                    w_rd        = 1'b1;
                    w_ld_ir     = 1'b1;
                    w_phase_nxt = PH_IDLE;
                end
                PH_IDLE: begin
                    w_sel       = 1'b1;
                    w_rd        = 1'b1;
                    w_ld_ir     = 1'b1;
                    w_phase_nxt = PH_OP_ADDR;
                end
                PH_OP_ADDR: begin
                    w_inc_pc = 1'b1;
                    // HLT freezes the phase here; it never reaches the retire edge.
                    if (w_is_hlt) begin
                        w_halt       = 1'b1;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = PH_OP_FETCH;
                    end
                end
                PH_OP_FETCH: begin
                    w_rd = w_aluop;
                    if (!w_aluop || w_mem_go) begin
                        w_phase_nxt = PH_ALU_OP;
                    end
                end
                PH_ALU_OP: begin
                    w_rd        = w_aluop;
                    w_inc_pc    = w_is_skz && bus.i_zero;
                    w_ld_pc     = w_is_jmp;
                    w_data_e    = w_is_sto;
                    w_phase_nxt = PH_STORE;
                end
                PH_STORE: begin
                    w_rd        = w_aluop;
                    w_ld_ac     = w_aluop;
                    w_ld_pc     = w_is_jmp;
                    w_wr        = w_is_sto;
                    w_data_e    = w_is_sto;
                    w_phase_nxt = PH_INST_ADDR;
                    if (!(&r_instr_cnt)) begin
                        w_instr_cnt_nxt = r_instr_cnt + 1'b1;
                    end
                end
                default: begin
                    w_phase_nxt = PH_INST_ADDR;
                end
            endcase
        end
    end

    assign bus.o_sel       = w_sel;
    assign bus.o_rd        = w_rd;
    assign bus.o_ld_ir     = w_ld_ir;
    assign bus.o_inc_pc    = w_inc_pc;
    assign bus.o_ld_pc     = w_ld_pc;
    assign bus.o_data_e    = w_data_e;
    assign bus.o_ld_ac     = w_ld_ac;
    assign bus.o_wr        = w_wr;
    assign bus.o_halt      = w_halt;
    assign bus.o_phase     = r_phase;
    assign bus.o_instr_cnt = r_instr_cnt;

endmodule : risc_sequencer
`default_nettype wire
